// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   640x480@60 timing constants shared by the sync generator and the sync
//   receiver, plus the receiver lock-state encoding.
package vga_timing_pkg;

    localparam int H_DISPLAY  = 640;  // visible pixels per line
    localparam int H_FRONT    = 16;   // horizontal front porch
    localparam int H_PULSE    = 96;   // h_sync width
    localparam int H_TOTAL    = 800;  // pixels per line
    localparam int V_DISPLAY  = 480;  // visible lines
    localparam int V_FRONT    = 10;   // vertical front porch
    localparam int V_PULSE    = 2;    // v_sync width
    localparam int V_TOTAL    = 525;  // lines per frame
    localparam int LOCK_LINES = 4;    // matched h edges needed to lock

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
//   Keeps the previous pixel-enabled sample of a sync line and flags rising
//   and falling edges of the current sample against it.
//   Ports:
//     clk_100MHz  system clock
//     reset_n     async active-low reset (prev resets to 1)
//     pixel_ce    sample enable
//     sync_in     current sync level (active-high)
//     rise        sync_in=1 and prev=0
//     fall        sync_in=0 and prev=1
module sync_edge_detect (
    input  logic clk_100MHz,
    input  logic reset_n,
    input  logic pixel_ce,
    input  logic sync_in,
    output logic rise,
    output logic fall
);

    logic sync_prev;

    // Reset to 1 so a pulse already in flight at reset release is not an edge.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n)
            sync_prev <= 1'b1;
        else if (pixel_ce)
            sync_prev <= sync_in;
    end

    assign rise = sync_in & ~sync_prev;
    assign fall = ~sync_in & sync_prev;

endmodule

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
//   Locks a local pixel/line counter to incoming h_sync/v_sync edges and
//   reports the recovered position, display area, frame start and a
//   saturating count of timing faults.
//   Ports:
//     clk_100MHz    system clock
//     reset_n       async active-low reset
//     pixel_ce      pixel enable; all sampling and counting gated by it
//     h_sync_in     horizontal sync, active-high
//     v_sync_in     vertical sync, active-high
//     x, y          recovered position of the pixel just sampled
//     display_true  locked and inside the visible area
//     locked        timing locked
//     frame_start   one-clock pulse at x=0,y=0 while locked
//     err_count     saturating timing-fault count
module vga_sync_receiver #(
    parameter int H_DISPLAY  = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT    = vga_timing_pkg::H_FRONT,
    parameter int H_PULSE    = vga_timing_pkg::H_PULSE,
    parameter int H_TOTAL    = vga_timing_pkg::H_TOTAL,
    parameter int V_DISPLAY  = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT    = vga_timing_pkg::V_FRONT,
    parameter int V_PULSE    = vga_timing_pkg::V_PULSE,
    parameter int V_TOTAL    = vga_timing_pkg::V_TOTAL,
    parameter int LOCK_LINES = vga_timing_pkg::LOCK_LINES
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       pixel_ce,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       display_true,
    output logic       locked,
    output logic       frame_start,
    output logic [7:0] err_count
);

    import vga_timing_pkg::*;

    // Positions at which sync edges are expected.
    localparam logic [9:0] HS     = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HE     = 10'(H_DISPLAY + H_FRONT + H_PULSE);
    localparam logic [9:0] VS     = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VE     = 10'(V_DISPLAY + V_FRONT + V_PULSE);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);

    localparam int             GW       = $clog2(LOCK_LINES + 1);
    localparam logic [GW-1:0]  GOOD_MAX = GW'(LOCK_LINES);

    rx_state_t     state, st_n;
    logic [GW-1:0] good_cnt, gc_n;
    logic          v_seen, vs_n;
    logic [9:0]    px, py, x_n, y_n;
    logic [7:0]    err_n;
    logic          h_rise, h_fall, v_rise, v_fall;
    logic          fault;

    sync_edge_detect u_h_edge (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .pixel_ce   (pixel_ce),
        .sync_in    (h_sync_in),
        .rise       (h_rise),
        .fall       (h_fall)
    );

    sync_edge_detect u_v_edge (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .pixel_ce   (pixel_ce),
        .sync_in    (v_sync_in),
        .rise       (v_rise),
        .fall       (v_fall)
    );

    // Predicted position of the current sample: free-running successor of
    // the last reported position.
    always_comb begin
        px = (x == H_LAST) ? 10'd0 : x + 10'd1;
        py = y;
        if (x == H_LAST)
            py = (y == V_LAST) ? 10'd0 : y + 10'd1;
    end

    // Pulse ends are checked as falling edges so that both too-long and
    // too-short pulses are caught at the expected end position. Several
    // violations on one sample collapse into a single fault.
    always_comb begin
        fault = 1'b0;
        if (px == HS && !h_rise)                 fault = 1'b1;
        if (px == HE && !h_fall)                 fault = 1'b1;
        if (h_rise && px != HS)                  fault = 1'b1;
        if (px == 10'd0 && py == VS && !v_rise)  fault = 1'b1;
        if (px == 10'd0 && py == VE && !v_fall)  fault = 1'b1;
        if (v_rise && !(px == 10'd0 && py == VS)) fault = 1'b1;
    end

    always_comb begin
        st_n  = state;
        x_n   = x;
        y_n   = y;
        gc_n  = good_cnt;
        vs_n  = v_seen;
        err_n = err_count;
        unique case (state)
            SEARCH: begin
                if (h_rise) begin
                    x_n  = HS;
                    gc_n = '0;
                    vs_n = 1'b0;
                    st_n = ACQUIRE;
                end
            end
            ACQUIRE: begin
                x_n = px;
                y_n = py;
                if (h_rise) begin
                    if (px == HS) begin
                        if (good_cnt != GOOD_MAX)
                            gc_n = good_cnt + GW'(1);
                    end else begin
                        x_n  = HS;
                        gc_n = '0;
                    end
                end
                if (v_rise) begin
                    y_n  = VS;
                    vs_n = 1'b1;
                end
                // Lock on the very sample that completes the qualification.
                if (gc_n == GOOD_MAX && vs_n)
                    st_n = LOCKED;
            end
            LOCKED: begin
                x_n = px;
                y_n = py;
                if (fault) begin
                    st_n = ACQUIRE;
                    gc_n = '0;
                    vs_n = 1'b0;
                    if (h_rise) x_n = HS;
                    if (v_rise) y_n = VS;
                    if (err_count != 8'hFF)
                        err_n = err_count + 8'd1;
                end
            end
            default: st_n = SEARCH;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state        <= SEARCH;
            good_cnt     <= '0;
            v_seen       <= 1'b0;
            x            <= '0;
            y            <= '0;
            err_count    <= '0;
            locked       <= 1'b0;
            display_true <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            // frame_start lasts one system clock, not one pixel.
            frame_start <= 1'b0;
            if (pixel_ce) begin
                state        <= st_n;
                good_cnt     <= gc_n;
                v_seen       <= vs_n;
                x            <= x_n;
                y            <= y_n;
                err_count    <= err_n;
                locked       <= (st_n == LOCKED);
                display_true <= (st_n == LOCKED) && (x_n < H_VIS) && (y_n < V_VIS);
                frame_start  <= (st_n == LOCKED) && (x_n == 10'd0) && (y_n == 10'd0);
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Scoreboard bench for vga_sync_receiver using a scaled-down timing
// (24x14 frame) so several frames fit in a short run. The stimulus drives
// a reference sync stream and queues the expected outputs per pixel; a
// monitor pops and compares after every sampled pixel.
module tb_vga_sync_receiver;

    localparam int H_D = 16, H_F = 2, H_P = 4, H_T = 24;
    localparam int V_D = 8,  V_F = 2, V_P = 2, V_T = 14;
    localparam int HS = H_D + H_F;          // 18
    localparam int HE = HS + H_P;           // 22
    localparam int VS = V_D + V_F;          // 10
    localparam int VE = VS + V_P;           // 12
    localparam int FRAME = H_T * V_T;       // 336 pixels

    logic       clk_100MHz = 1'b0;
    logic       reset_n    = 1'b1;
    logic       pixel_ce   = 1'b0;
    logic       h_sync_in  = 1'b0;
    logic       v_sync_in  = 1'b0;
    logic [9:0] x, y;
    logic       display_true, locked, frame_start;
    logic [7:0] err_count;

    vga_sync_receiver #(
        .H_DISPLAY(H_D), .H_FRONT(H_F), .H_PULSE(H_P), .H_TOTAL(H_T),
        .V_DISPLAY(V_D), .V_FRONT(V_F), .V_PULSE(V_P), .V_TOTAL(V_T),
        .LOCK_LINES(4)
    ) dut (
        .clk_100MHz   (clk_100MHz),
        .reset_n      (reset_n),
        .pixel_ce     (pixel_ce),
        .h_sync_in    (h_sync_in),
        .v_sync_in    (v_sync_in),
        .x            (x),
        .y            (y),
        .display_true (display_true),
        .locked       (locked),
        .frame_start  (frame_start),
        .err_count    (err_count)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct {
        int sx, sy;
        bit chk_xy;
        int ex, ey;
        bit lk;
        int err;
        bit dt;
        bit fs;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   fs_clks = 0;

    // Source position and expected-state bookkeeping
    int sx = 0, sy = 0;
    bit exp_lk = 0, exp_search = 0;
    int exp_err = 0;
    int inj_y = -1, inj_kind = 0;
    int drop_x = -1, drop_y = -1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // One source pixel: compute sync levels, queue expectation, pulse ce.
    task automatic step(input bit chk_on);
        exp_t e;
        bit   hs, vs;
        hs = (sx >= HS && sx < HE);
        vs = (sy >= VS && sy < VE);
        if (sy == inj_y) begin
            if (inj_kind == 1) hs = (sx >= HS + 1 && sx < HE + 1); // shifted +1
            else               hs = (sx >= HS && sx < HE - 1);     // one short
        end
        if (chk_on) begin
            if (exp_lk && sx == drop_x && sy == drop_y) begin
                exp_lk = 0;
                exp_err++;
                drop_y = -1;
            end else if (!exp_lk && !exp_search && sx == 0 && sy == VS) begin
                exp_lk = 1;
            end
            e.sx = sx; e.sy = sy;
            e.lk = exp_lk; e.err = exp_err;
            e.dt = exp_lk && sx < H_D && sy < V_D;
            e.fs = exp_lk && sx == 0 && sy == 0;
            e.chk_xy = exp_lk || exp_search;
            e.ex = sx; e.ey = sy;
            if (exp_search) begin
                e.ex = (sx == HS) ? HS : 0;
                e.ey = 0;
                if (sx == HS) exp_search = 0;
            end
            exp_q.push_back(e);
        end
        h_sync_in = hs;
        v_sync_in = vs;
        pixel_ce  = 1'b1;
        @(negedge clk_100MHz);
        pixel_ce = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        if (sy == inj_y && sx == H_T - 1) inj_y = -1;
        if (sx == H_T - 1) begin
            sx = 0;
            sy = (sy == V_T - 1) ? 0 : sy + 1;
        end else begin
            sx++;
        end
    endtask

    // Monitor: compare after every sampled pixel.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_100MHz);
            if (pixel_ce && reset_n) begin
                #1;
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk_xy) begin
                        chk($sformatf("x(%0d,%0d)", e.sx, e.sy), int'(x), e.ex);
                        chk($sformatf("y(%0d,%0d)", e.sx, e.sy), int'(y), e.ey);
                    end
                    chk($sformatf("locked(%0d,%0d)", e.sx, e.sy), int'(locked), int'(e.lk));
                    chk($sformatf("err_count(%0d,%0d)", e.sx, e.sy), int'(err_count), e.err);
                    chk($sformatf("display_true(%0d,%0d)", e.sx, e.sy), int'(display_true), int'(e.dt));
                    chk($sformatf("frame_start(%0d,%0d)", e.sx, e.sy), int'(frame_start), int'(e.fs));
                end
            end
        end
    end

    // Asynchronous reset: outputs must clear before any clock edge.
    initial begin
        forever begin
            @(negedge reset_n);
            #1;
            chk("rst_x", int'(x), 0);
            chk("rst_y", int'(y), 0);
            chk("rst_display_true", int'(display_true), 0);
            chk("rst_locked", int'(locked), 0);
            chk("rst_frame_start", int'(frame_start), 0);
            chk("rst_err_count", int'(err_count), 0);
        end
    end

    always @(negedge clk_100MHz) if (frame_start) fs_clks++;

    initial begin
        int fs0;
        #3 reset_n = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        reset_n = 1'b1;
        exp_search = 1;

        // Clean stream from reset: acquire, lock at (0,VS), track to frame end.
        repeat (FRAME) step(1);

        // Two locked frames: exactly two one-clock frame_start pulses.
        fs0 = fs_clks;
        repeat (2 * FRAME) step(1);
        chk("fs_count_2frames", fs_clks - fs0, 2);

        // h pulse shifted +1 on line 3: fault at the missing edge (x=HS).
        inj_y = 3; inj_kind = 1; drop_x = HS; drop_y = 3;
        repeat (FRAME) step(1);

        // h pulse one pixel short on line 3: fault at x=HE.
        inj_y = 3; inj_kind = 2; drop_x = HE; drop_y = 3;
        repeat (FRAME) step(1);

        // Mid-line reset at (5,2) while locked, then reacquire.
        repeat (2 * H_T + 5) step(1);
        reset_n = 1'b0;
        repeat (2) step(0);
        reset_n = 1'b1;
        exp_lk = 0; exp_err = 0; exp_search = 1;
        while (!(sx == 0 && sy == 0)) step(1);

        // Reset released during an h pulse: that pulse must not count.
        repeat (H_T + 19) step(1);
        reset_n = 1'b0;
        step(0);
        reset_n = 1'b1;
        exp_lk = 0; exp_err = 0; exp_search = 1;
        repeat (FRAME) step(1);

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
